interleaver_serializer: RTL and testbench

INTERLEAVER_SERIALIZER -- requirements
Module: interleaver_serializer

---
 rtl/interleaver_pkg.sv | 13 +
 rtl/serial_bit_counter.sv | 31 +++
 rtl/interleaver_serializer.sv | 121 ++++++++++++
 tb/tb_interleaver_serializer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interleaver_pkg.sv
// Shared constants and FSM state type for the interleaver serializer.
package interleaver_pkg;

    localparam int unsigned K_SMALL = 1056;
    localparam int unsigned K_LARGE = 6144;
    localparam int unsigned CNT_W   = 13;

    typedef enum logic {
        StIdle,
        StShift
    } state_t;

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable down-counter that tracks the remaining bits of the current block.
// Load has priority over decrement, and the count saturates at zero.
module serial_bit_counter
    import interleaver_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_value,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load, or count down towards zero without wrapping.
    always_ff @(posedge i_clk or posedge i_clear) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule

// File: rtl/interleaver_serializer.sv
// Serializes an interleaved parallel block (1056 or 6144 bits) MSB-first.
// Optional feature: define SERIALIZER_LAST_EN to add the 'last' output that
// flags the final valid bit of each block.
module interleaver_serializer
    import interleaver_pkg::*;
#(
    parameter int unsigned KMAX = K_LARGE,
    parameter int unsigned KMIN = K_SMALL
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            k_size,
    input  logic            load,
    input  logic [KMAX-1:0] din,
    input  logic            out_en,
    output logic            load_ack,
    output logic            busy,
    output logic            databit_out,
    output logic            dout_valid,
    output logic            block_done
`ifdef SERIALIZER_LAST_EN
    ,
    output logic            last
`endif
);

    state_t           r_state;
    logic [KMAX-1:0]  r_sr;     // bits still to be presented after the current one
    logic             r_bit;
    logic             r_valid;
    logic             r_ack;
    logic             r_done;
`ifdef SERIALIZER_LAST_EN
    logic             r_last;
`endif

    logic [CNT_W-1:0] w_count;
    logic             w_zero;
    logic             w_consume;
    logic             w_last;
    logic             w_accept;
    logic             w_cnt_en;
    logic [KMAX-1:0]  w_aligned;
    logic [CNT_W-1:0] w_load_val;

    // The block size is captured by the counter preload and the MSB alignment,
    // so no separate size register is needed after accept.
    assign w_aligned  = k_size ? din : (din << (KMAX - KMIN));
    assign w_load_val = k_size ? CNT_W'(KMAX - 1) : CNT_W'(KMIN - 1);

    assign w_consume = (r_state == StShift) && out_en;
    assign w_last    = w_consume && w_zero;
    assign w_accept  = load && ((r_state == StIdle) || w_last);
    assign w_cnt_en  = w_consume && !w_zero;

    serial_bit_counter u_counter (
        .i_clk   (clk),
        .i_clear (clear),
        .i_load  (w_accept),
        .i_value (w_load_val),
        .i_en    (w_cnt_en),
        .o_count (w_count),
        .o_zero  (w_zero)
    );

    // FSM with registered outputs: accept, shift on out_en, return to idle.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state <= StIdle;
            r_sr    <= '0;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_ack   <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIALIZER_LAST_EN
            r_last  <= 1'b0;
`endif
        end else begin
            r_ack  <= w_accept;
            r_done <= w_last;
            if (w_accept) begin
                r_state <= StShift;
                r_bit   <= w_aligned[KMAX-1];
                r_sr    <= w_aligned << 1;
                r_valid <= 1'b1;
`ifdef SERIALIZER_LAST_EN
                r_last  <= 1'b0;
`endif
            end else if (w_last) begin
                r_state <= StIdle;
                r_bit   <= 1'b0;
                r_sr    <= '0;
                r_valid <= 1'b0;
`ifdef SERIALIZER_LAST_EN
                r_last  <= 1'b0;
`endif
            end else if (w_consume) begin
                r_bit <= r_sr[KMAX-1];
                r_sr  <= r_sr << 1;
`ifdef SERIALIZER_LAST_EN
                // Count reaches zero at this edge: the next bit is the final one.
                r_last <= (w_count == CNT_W'(1));
`endif
            end
        end
    end

`ifdef SERIALIZER_LAST_EN
    assign last = r_last;
`else
    logic w_unused_count;
    assign w_unused_count = ^w_count;
`endif

    assign busy        = (r_state == StShift);
    assign dout_valid  = r_valid;
    assign databit_out = r_bit;
    assign load_ack    = r_ack;
    assign block_done  = r_done;

endmodule

// File: tb/tb_interleaver_serializer.sv
// Directed self-checking bench for interleaver_serializer.
module tb_interleaver_serializer;

    localparam int KMAX = 6144;
    localparam int KMIN = 1056;

    logic            clk;
    logic            clear;
    logic            k_size;
    logic            load;
    logic [KMAX-1:0] din;
    logic            out_en;
    logic            load_ack;
    logic            busy;
    logic            databit_out;
    logic            dout_valid;
    logic            block_done;
`ifdef SERIALIZER_LAST_EN
    logic            last;
`endif

    int n_pass;
    int n_total;

    // Results of the most recent capture run.
    bit q_bits[$];
    bit q_stall[$];
    int ack_cyc[$];
    int done_pos[$];
    int last_pos[$];
    int zero_err;
    int busy_err;
    int last_err;
    bit timed_out;

    interleaver_serializer #(
        .KMAX (KMAX),
        .KMIN (KMIN)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .k_size      (k_size),
        .load        (load),
        .din         (din),
        .out_en      (out_en),
        .load_ack    (load_ack),
        .busy        (busy),
        .databit_out (databit_out),
        .dout_valid  (dout_valid),
        .block_done  (block_done)
`ifdef SERIALIZER_LAST_EN
        ,
        .last        (last)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic exp_bit(input logic [KMAX-1:0] d, input logic ks, input int j);
        int k;
        k = ks ? KMAX : KMIN;
        return d[k-1-j];
    endfunction

    function automatic logic [KMAX-1:0] alt_small();
        logic [KMAX-1:0] d;
        d = '1;  // bits above 1055 must be ignored for the small size
        for (int i = 0; i < KMIN; i++) d[i] = (i % 2 == 1);
        return d;
    endfunction

    // Runs the stream from the negedge after the block was presented, recording
    // consumed bits and pulse positions. Drives out_en and, optionally, a stall,
    // a stray load pulse, or an early stop before consuming bit stop_at.
    task automatic capture(input int stop_at, input int stall_at, input int stall_len,
                           input int pulse_at, input logic [KMAX-1:0] din_pulse,
                           input logic [KMAX-1:0] din_after, input bit load_after,
                           input int max_cyc);
        int  n_valid;
        int  stall_left;
        int  idle_run;
        bit  pulse_drop;
        bit  pulse_done;
        q_bits.delete();
        q_stall.delete();
        ack_cyc.delete();
        done_pos.delete();
        last_pos.delete();
        zero_err   = 0;
        busy_err   = 0;
        last_err   = 0;
        timed_out  = 1'b1;
        n_valid    = 0;
        stall_left = stall_len;
        idle_run   = 0;
        pulse_drop = 1'b0;
        pulse_done = 1'b0;
        for (int cyc = 0; cyc < max_cyc; cyc++) begin
            @(negedge clk);
            if (load_ack) ack_cyc.push_back(cyc);
            if (block_done) done_pos.push_back(n_valid);
            if (!dout_valid && databit_out !== 1'b0) zero_err++;
            if (busy !== dout_valid) busy_err++;
`ifdef SERIALIZER_LAST_EN
            if (last) last_pos.push_back(n_valid);
            if (last && !dout_valid) last_err++;
`endif
            if (cyc == 0) begin
                din  = din_after;
                load = load_after;
            end else if (load_ack) begin
                load = 1'b0;
            end
            if (pulse_drop) begin
                load       = 1'b0;
                pulse_drop = 1'b0;
            end
            if (stop_at >= 0 && n_valid == stop_at && dout_valid) begin
                timed_out = 1'b0;
                break;
            end
            out_en = 1'b1;
            if (stall_at >= 0 && n_valid == stall_at && stall_left > 0 && dout_valid) begin
                out_en = 1'b0;
                stall_left--;
                q_stall.push_back(databit_out);
            end
            if (pulse_at >= 0 && n_valid == pulse_at && !pulse_done && dout_valid) begin
                load       = 1'b1;
                din        = din_pulse;
                pulse_drop = 1'b1;
                pulse_done = 1'b1;
            end
            if (dout_valid && out_en) begin
                q_bits.push_back(databit_out);
                n_valid++;
            end
            if (!dout_valid && n_valid > 0) begin
                idle_run++;
                if (idle_run >= 3) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        out_en = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        clear = 1'b1;
        load  = 1'b1;
        #1;
        n_total++;
        if ({busy, dout_valid, databit_out, load_ack, block_done} !== 5'b0)
            $display("FAIL reset_async outs=%b want 00000",
                     {busy, dout_valid, databit_out, load_ack, block_done});
        else n_pass++;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, dout_valid, databit_out, load_ack, block_done} !== 5'b0)
            $display("FAIL reset_load_ignored outs=%b want 00000",
                     {busy, dout_valid, databit_out, load_ack, block_done});
        else n_pass++;
        load  = 1'b0;
        clear = 1'b0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({busy, dout_valid, load_ack} !== 3'b0)
            $display("FAIL reset_idle outs=%b want 000", {busy, dout_valid, load_ack});
        else n_pass++;
    endtask

    task automatic test_small_alt();
        logic [KMAX-1:0] d;
        int err;
        d = alt_small();
        @(negedge clk);
        din = d; k_size = 1'b0; load = 1'b1; out_en = 1'b1;
        capture(-1, -1, 0, -1, '0, d, 1'b0, 3000);
        err = 0;
        for (int j = 0; j < q_bits.size(); j++) if (q_bits[j] !== exp_bit(d, 1'b0, j)) err++;
        n_total++;
        if (timed_out) $display("FAIL small_timeout got 1 want 0"); else n_pass++;
        n_total++;
        if (q_bits.size() !== KMIN) $display("FAIL small_len got %0d want %0d", q_bits.size(), KMIN);
        else n_pass++;
        n_total++;
        if (err !== 0 || q_bits.size() == 0 || q_bits[0] !== 1'b1)
            $display("FAIL small_bits errors=%0d want 0", err);
        else n_pass++;
        n_total++;
        if (ack_cyc.size() !== 1 || ack_cyc[0] !== 0)
            $display("FAIL small_ack count=%0d want 1 at cycle 0", ack_cyc.size());
        else n_pass++;
        n_total++;
        if (done_pos.size() !== 1 || done_pos[0] !== KMIN)
            $display("FAIL small_done count=%0d want 1 after bit %0d", done_pos.size(), KMIN);
        else n_pass++;
        n_total++;
        if (zero_err !== 0 || busy_err !== 0)
            $display("FAIL small_idle_outs zero_err=%0d busy_err=%0d want 0", zero_err, busy_err);
        else n_pass++;
    endtask

    task automatic test_large_lsb();
        logic [KMAX-1:0] d;
        int ones;
        int one_at;
        d = '0;
        d[0] = 1'b1;
        @(negedge clk);
        din = d; k_size = 1'b1; load = 1'b1;
        capture(-1, -1, 0, -1, '0, '0, 1'b0, 7000);
        ones = 0;
        one_at = -1;
        for (int j = 0; j < q_bits.size(); j++) if (q_bits[j]) begin ones++; one_at = j; end
        n_total++;
        if (q_bits.size() !== KMAX || timed_out)
            $display("FAIL large_len got %0d want %0d", q_bits.size(), KMAX);
        else n_pass++;
        n_total++;
        if (ones !== 1 || one_at !== KMAX - 1)
            $display("FAIL large_lsb ones=%0d at %0d want 1 at %0d", ones, one_at, KMAX - 1);
        else n_pass++;
        n_total++;
        if (done_pos.size() !== 1 || done_pos[0] !== KMAX)
            $display("FAIL large_done count=%0d want 1", done_pos.size());
        else n_pass++;
`ifdef SERIALIZER_LAST_EN
        n_total++;
        if (last_pos.size() !== 1 || last_pos[0] !== KMAX - 1 || last_err !== 0)
            $display("FAIL large_last count=%0d want 1 at bit %0d", last_pos.size(), KMAX - 1);
        else n_pass++;
`endif
    endtask

    task automatic test_back_to_back();
        logic [KMAX-1:0] a;
        logic [KMAX-1:0] b;
        int err;
        a = alt_small();
        b = '0;
        for (int i = 0; i < KMIN; i++) b[i] = (i % 3 == 0);
        @(negedge clk);
        din = a; k_size = 1'b0; load = 1'b1;
        capture(-1, -1, 0, -1, '0, b, 1'b1, 5000);
        err = 0;
        for (int j = 0; j < q_bits.size(); j++) begin
            if (j < KMIN) begin
                if (q_bits[j] !== exp_bit(a, 1'b0, j)) err++;
            end else begin
                if (q_bits[j] !== exp_bit(b, 1'b0, j - KMIN)) err++;
            end
        end
        n_total++;
        if (q_bits.size() !== 2 * KMIN || timed_out)
            $display("FAIL b2b_len got %0d want %0d", q_bits.size(), 2 * KMIN);
        else n_pass++;
        n_total++;
        if (err !== 0) $display("FAIL b2b_bits errors=%0d want 0", err); else n_pass++;
        n_total++;
        if (ack_cyc.size() !== 2 || ack_cyc[0] !== 0 || ack_cyc[1] !== KMIN)
            $display("FAIL b2b_ack count=%0d want 2 at cycles 0 and %0d", ack_cyc.size(), KMIN);
        else n_pass++;
        n_total++;
        if (done_pos.size() !== 2 || done_pos[0] !== KMIN || done_pos[1] !== 2 * KMIN)
            $display("FAIL b2b_done count=%0d want 2", done_pos.size());
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [KMAX-1:0] d;
        int err;
        int frz;
        d = {384{16'hA5C3}};
        @(negedge clk);
        din = d; k_size = 1'b1; load = 1'b1;
        capture(-1, 100, 5, -1, '0, d, 1'b0, 7000);
        err = 0;
        for (int j = 0; j < q_bits.size(); j++) if (q_bits[j] !== exp_bit(d, 1'b1, j)) err++;
        frz = 0;
        for (int j = 0; j < q_stall.size(); j++) if (q_stall[j] !== exp_bit(d, 1'b1, 100)) frz++;
        n_total++;
        if (q_stall.size() !== 5 || frz !== 0)
            $display("FAIL stall_frozen samples=%0d bad=%0d want 5 and 0", q_stall.size(), frz);
        else n_pass++;
        n_total++;
        if (q_bits.size() !== KMAX || timed_out)
            $display("FAIL stall_len got %0d want %0d", q_bits.size(), KMAX);
        else n_pass++;
        n_total++;
        if (err !== 0) $display("FAIL stall_bits errors=%0d want 0", err); else n_pass++;
    endtask

    task automatic test_clear_mid();
        logic [KMAX-1:0] d;
        int dones;
        int err;
        d = '1;
        @(negedge clk);
        din = d; k_size = 1'b1; load = 1'b1;
        capture(500, -1, 0, -1, '0, d, 1'b0, 1000);
        n_total++;
        if (timed_out || q_bits.size() !== 500)
            $display("FAIL clear_reach got %0d bits want 500", q_bits.size());
        else n_pass++;
        #1;
        clear = 1'b1;
        load  = 1'b1;
        #1;
        n_total++;
        if ({busy, dout_valid, databit_out, load_ack, block_done} !== 5'b0)
            $display("FAIL clear_async outs=%b want 00000",
                     {busy, dout_valid, databit_out, load_ack, block_done});
        else n_pass++;
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (block_done || dout_valid) dones++;
        end
        clear = 1'b0;
        load  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (block_done || dout_valid || load_ack) dones++;
        end
        n_total++;
        if (dones !== 0) $display("FAIL clear_no_done events=%0d want 0", dones); else n_pass++;
        d = alt_small();
        din = d; k_size = 1'b0; load = 1'b1;
        capture(-1, -1, 0, -1, '0, d, 1'b0, 3000);
        err = 0;
        for (int j = 0; j < q_bits.size(); j++) if (q_bits[j] !== exp_bit(d, 1'b0, j)) err++;
        n_total++;
        if (q_bits.size() !== KMIN || err !== 0 || done_pos.size() !== 1)
            $display("FAIL clear_restart len=%0d errors=%0d want %0d and 0",
                     q_bits.size(), err, KMIN);
        else n_pass++;
    endtask

    task automatic test_ignore_load();
        logic [KMAX-1:0] a;
        int err;
        a = '0;
        a[KMIN-1:0] = {66{16'h3C96}};
        @(negedge clk);
        din = a; k_size = 1'b0; load = 1'b1;
        capture(-1, -1, 0, 10, ~a, a, 1'b0, 3000);
        err = 0;
        for (int j = 0; j < q_bits.size(); j++) if (q_bits[j] !== exp_bit(a, 1'b0, j)) err++;
        n_total++;
        if (ack_cyc.size() !== 1)
            $display("FAIL ignore_ack count=%0d want 1", ack_cyc.size());
        else n_pass++;
        n_total++;
        if (q_bits.size() !== KMIN || err !== 0 || timed_out)
            $display("FAIL ignore_stream len=%0d errors=%0d want %0d and 0",
                     q_bits.size(), err, KMIN);
        else n_pass++;
        n_total++;
        if (done_pos.size() !== 1 || done_pos[0] !== KMIN)
            $display("FAIL ignore_done count=%0d want 1", done_pos.size());
        else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        clear   = 1'b0;
        k_size  = 1'b0;
        load    = 1'b0;
        din     = '0;
        out_en  = 1'b1;
        test_reset();
        test_small_alt();
        test_large_lsb();
        test_back_to_back();
        test_stall();
        test_clear_mid();
        test_ignore_load();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
